// File: rtl/pc_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_fetch : instruction-fetch stage; owns the PC and feeds the IF/ID reg.   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16,
   parameter int          CNT_W    = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_ack,
   input  logic [31:0] inst_rdata,
   output logic [31:0] pc_pc,
   output logic [31:0] pc_inst,
   output logic        pc_adel,
   output logic        stallreq_if,
   output logic        fetch_err
);

   localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [31:0]      r_pc;
   logic [31:0]      r_buf;
   logic             r_pend;
   logic [31:0]      r_pend_pc;
   logic [CNT_W-1:0] r_cnt;

   logic             w_aligned;
   logic             w_hold;
   logic             w_adv;
   logic             w_capture;
   logic             w_wait;
   logic [31:0]      w_next_pc;
   logic             w_unused;

   assign w_unused  = ^{stall[5:2], stall[0]};
   assign w_aligned = (r_pc[1:0] == 2'b00);
   assign w_hold    = stall[1];
   assign inst_addr = r_pc;
   assign w_next_pc = branch_flag ? branch_target :
                      r_pend      ? r_pend_pc     : r_pc + 32'd4;

   always_comb begin
      w_state_nxt = r_state;
      inst_req    = 1'b0;
      pc_pc       = 32'd0;
      pc_inst     = 32'd0;
      pc_adel     = 1'b0;
      w_adv       = 1'b0;
      w_capture   = 1'b0;
      w_wait      = 1'b0;
      case (r_state)
         S_IDLE: w_state_nxt = S_FETCH;
         S_FETCH: begin
            if (!w_aligned) begin
               // Misaligned PC becomes a word of its own carrying the address error.
               pc_pc   = r_pc;
               pc_adel = 1'b1;
               w_adv   = !w_hold;
            end else begin
               inst_req = 1'b1;
               if (inst_ack) begin
                  pc_pc   = r_pc;
                  pc_inst = inst_rdata;
                  if (w_hold) begin
                     w_capture   = 1'b1;
                     w_state_nxt = S_HOLD;
                  end else begin
                     w_adv = 1'b1;
                  end
               end else begin
                  w_wait = 1'b1;
               end
            end
         end
         S_HOLD: begin
            pc_pc   = r_pc;
            pc_inst = r_buf;
            pc_adel = !w_aligned;
            if (!w_hold) begin
               w_adv       = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush) begin
         w_state_nxt = S_FETCH;
         pc_pc       = 32'd0;
         pc_inst     = 32'd0;
         pc_adel     = 1'b0;
         w_adv       = 1'b0;
         w_capture   = 1'b0;
         w_wait      = 1'b0;
      end
   end

   assign stallreq_if = w_wait;
   assign fetch_err   = w_wait && (r_cnt == c_TMO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_pc      <= RESET_PC;
         r_buf     <= 32'd0;
         r_pend    <= 1'b0;
         r_pend_pc <= 32'd0;
         r_cnt     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (flush) begin
            r_pc   <= new_pc;
            r_buf  <= 32'd0;
            r_pend <= 1'b0;
            r_cnt  <= '0;
         end else begin
            if (w_adv) begin
               r_pc   <= w_next_pc;
               r_pend <= 1'b0;
            end else if (branch_flag) begin
               r_pend    <= 1'b1;
               r_pend_pc <= branch_target;
            end
            if (w_capture) begin
               r_buf <= inst_rdata;
            end
            // Counter only runs while the request is outstanding; wraps after a timeout pulse.
            if (w_wait) begin
               r_cnt <= fetch_err ? '0 : r_cnt + CNT_W'(1);
            end else begin
               r_cnt <= '0;
            end
         end
      end
   end

endmodule
`default_nettype wire
